mux_2to1_8bit_arbiter: RTL

//   Round-robin arbiter sharing one mux_2to1_8bit between two requesters.

---
 rtl/mux_2to1_8bit_arbiter_pkg.sv | 12 +
 rtl/mux_2to1_8bit_arbiter_mux.sv | 9 +
 rtl/mux_2to1_8bit_arbiter.sv | 80 ++++++++
 3 files changed

// File: rtl/mux_2to1_8bit_arbiter_pkg.sv
// mux_2to1_8bit_arbiter_pkg: shared FSM encoding and round-robin pick for the arbiter
package mux_2to1_8bit_arbiter_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
        return (r0 && r1) ? ~last : r1;
    endfunction
endpackage

// File: rtl/mux_2to1_8bit_arbiter_mux.sv
// mux_2to1_8bit: plain 8-bit two-input multiplexer (0=in0, 1=in1)
module mux_2to1_8bit (
    input  logic       sel,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    output logic [7:0] mux_out
);
    assign mux_out = sel ? in1 : in0;
endmodule

// File: rtl/mux_2to1_8bit_arbiter.sv
// mux_2to1_8bit_arbiter: round-robin arbiter sharing one 8-bit mux, registered valid/ready output
module mux_2to1_8bit_arbiter
    import mux_2to1_8bit_arbiter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] in0,
    input  logic             req1,
    input  logic [WIDTH-1:0] in1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    state_e           state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [7:0]       mux_out;
    mux_2to1_8bit u_mux (
        .sel    (sel_q),
        .in0    (in0),
        .in1    (in1),
        .mux_out(mux_out)
    );
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            ST_LOAD: begin
                out_data_d  = mux_out;
                out_valid_d = 1'b1;
                last_d      = sel_q;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    sel_d       = (req0 || req1) ? rr_pick(req0, req1, last_q) : sel_q;
                    state_d     = (req0 || req1) ? ST_LOAD : ST_IDLE;
                end
            end
            // the unused fourth encoding behaves as IDLE
            default: begin
                sel_d   = (req0 || req1) ? rr_pick(req0, req1, last_q) : sel_q;
                state_d = (req0 || req1) ? ST_LOAD : ST_IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= 1'b0;
            last_q      <= ~FIRST_PRIO;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
    assign gnt0      = (state_q == ST_LOAD) && !sel_q;
    assign gnt1      = (state_q == ST_LOAD) && sel_q;
    assign sel       = sel_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
endmodule
